gbf_o_drain: RTL and testbench
==============================

# gbf_o_drain

Result-drain engine for the output global buffer (GBF_o). After the matrix-multiply datapath asserts `done`, this block reads a contiguous range of result words out of one GBF_o read port and streams them out over a valid/ready interface toward the host or DMA. It is the reader counterpart to the datapath's GBF_o write ports. It replaces file dumps of GBF_o with a synthesizable path.

## Interface
Parameters:
- `WIDTH`, 32, result word width.
- `HEIGHT_O`, 160, GBF_o depth in words; `AW = $clog2(HEIGHT_O)`.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — reset, synchronous and active-low.
- `start`  in  1  — begin drain; sampled only when idle.
- `base_addr`  in  AW  — first GBF_o address, latched on accepted `start`.
- `num_words`  in  AW+1  — word count, latched on accepted `start`; values >HEIGHT_O saturate to HEIGHT_O.
- `rd_addr`  out  AW  — GBF_o port address (registered).
- `rd_en`  out  1  — read issued this cycle.
- `rd_data`  in  WIDTH  — GBF_o port q; valid the cycle after the `rd_en` cycle.
- `m_data`  out  WIDTH  — stream data.
- `m_valid`  out  1  — stream valid.
- `m_ready`  in  1  — stream ready.
- `m_last`  out  1  — marks the final word, qualified by `m_valid`.
- `busy`  out  1  — high from accepted `start` until the final handshake.
- `drained`  out  1  — one-cycle pulse after the final handshake.

## Operation
- FSM has three states: IDLE, READ, FLUSH.
  - IDLE → READ on `start` with latched count >0.
  - IDLE → IDLE on `start` with count 0. Pulse `drained` the next cycle; `busy` stays low; no `rd_en` is issued.
  - READ → FLUSH after the last `rd_en` is issued.
  - FLUSH → IDLE on the handshake of the word with `m_last`.
- `start` is ignored in READ and FLUSH.
- Address for word i is `(base_addr + i) mod HEIGHT_O`. Reads wrap past HEIGHT_O-1 to 0.
- Output path is a 2-entry FIFO.
  - `rd_en` is issued only when occupancy + in-flight reads − (pop this cycle) < 2. This guarantees no overflow.
  - Read data is pushed unconditionally on the cycle after `rd_en`.
- Stream rule: once `m_valid` is high, `m_data`, `m_valid` and `m_last` hold until `m_valid && m_ready`.
- Words leave in address order. Exactly `num_words` handshakes occur per drain.
- Word count uses a separate AW+1-bit down-counter. Address arithmetic is AW bits with explicit modulo HEIGHT_O. This matters because HEIGHT_O need not be a power of 2.

## Timing
- All outputs reset to 0 and the FSM resets to IDLE. Any in-flight read data is discarded and the FIFO is emptied.
- Reset mid-drain: `m_valid` is low in the cycle after the reset edge. No `drained` pulse is generated.
- Latency, with `start` sampled at edge E0:
  - `rd_en=1`, `rd_addr=base_addr` in cycle E0→E1.
  - `rd_data` is valid in E1→E2 and captured at E2.
  - `m_valid=1` from E2.
- With `m_ready` held high, throughput is 1 word/cycle. An N-word drain finishes with the last handshake at edge E(N+2). `drained` is high during cycle E(N+2)→E(N+3).
- `m_ready` low for k cycles stalls issue within 1 cycle. Nothing is lost or duplicated.
- `busy` falls in the same cycle `drained` rises.

## Configuration
- `GBF_O_DRAIN_CLEAR_EN` defined: adds ports `clr_addr` (out, AW), `clr_we` (out, 1) and `clr_data` (out, WIDTH, constant 0). These drive a second GBF_o port.
  - For each word pushed into the FIFO, `clr_we=1` is asserted that cycle, with `clr_addr` equal to that word's read address.
  - The location is zeroed so the next tile accumulates from 0.
  - `clr_we` resets to 0.
- `GBF_O_DRAIN_CLEAR_EN` not defined: these ports do not exist and GBF_o contents are untouched.

## Test plan
- base 0, num 10, `m_ready`=1 → `rd_addr` 0..9 on consecutive cycles; first `m_valid` 2 cycles after `start`; 10 handshakes in order with `m_last` on the 10th; `drained` pulses at start+12.
- base 155, num 10, HEIGHT_O 160 → addresses 155..159 then 0..4; data order matches.
- num 4, `m_ready` toggled 1,0,0,1,0,1… → 4 handshakes in order; `m_data` stable during stalls; FIFO never overflows (assertion).
- num 0 → no `rd_en`, no `m_valid`; `drained` pulses 1 cycle after `start`; `busy` stays 0. A second `start` during a 10-word drain is ignored.
- `rst`=0 asserted at the 3rd handshake of a 10-word drain → outputs 0 next cycle, no `drained`; a new drain afterwards runs cleanly.
- With `GBF_O_DRAIN_CLEAR_EN`: drain base 20, num 5 → GBF_o[20..24] read 0 afterward; GBF_o[25] is unchanged.

Source files
------------

// File: rtl/gbf_o_drain.sv
// ---------------------------------------------------------------------------
// gbf_o_drain
//
// Result-drain engine for the output global buffer (GBF_o). Once the matmul
// datapath has finished, a host/DMA kicks this block with a base address and
// a word count; it reads that contiguous (wrapping) range out of one GBF_o
// read port and streams the words out over a valid/ready interface.
//
// Optional feature (macro GBF_O_DRAIN_CLEAR_EN):
//   When defined, a second GBF_o write port is driven so that every word that
//   is drained is also zeroed in place, leaving the buffer ready for the next
//   tile to accumulate from 0. When undefined, the clear ports do not exist
//   and GBF_o contents are never modified.
//
// Parameters:
//   WIDTH     result word width
//   HEIGHT_O  GBF_o depth in words (need not be a power of two)
//   AW        GBF_o address width, $clog2(HEIGHT_O)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-low reset
//   start      begin a drain; only looked at while idle
//   base_addr  first GBF_o address, latched on an accepted start
//   num_words  word count, latched on an accepted start, saturates at HEIGHT_O
//   rd_addr    GBF_o read address (registered)
//   rd_en      read strobe; rd_data is valid the following cycle
//   rd_data    GBF_o read data
//   m_data     stream data
//   m_valid    stream valid
//   m_ready    stream ready
//   m_last     final word of the drain, qualified by m_valid
//   busy       high from an accepted start until the final handshake
//   drained    one-cycle pulse after the final handshake
//   clr_addr   (CLEAR_EN only) GBF_o clear address
//   clr_we     (CLEAR_EN only) GBF_o clear write enable
//   clr_data   (CLEAR_EN only) GBF_o clear data, always 0
// ---------------------------------------------------------------------------
module gbf_o_drain #(
  parameter int WIDTH    = 32,
  parameter int HEIGHT_O = 160,
  localparam int AW      = $clog2(HEIGHT_O)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW:0]      num_words,
  output logic [AW-1:0]    rd_addr,
  output logic             rd_en,
  input  logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy,
  output logic             drained
`ifdef GBF_O_DRAIN_CLEAR_EN
  ,
  output logic [AW-1:0]    clr_addr,
  output logic             clr_we,
  output logic [WIDTH-1:0] clr_data
`endif
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(HEIGHT_O - 1);
  localparam logic [AW-1:0] DEPTH_AW  = AW'(HEIGHT_O);
  localparam logic [AW:0]   MAX_WORDS = (AW + 1)'(HEIGHT_O);
  localparam logic [AW:0]   ONE_WORD  = (AW + 1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    FLUSH
  } state_t;

  state_t           state;

  // reads_left counts reads still to issue, pops_left counts handshakes still
  // to happen; both are full AW+1 bits so a whole-buffer drain fits.
  logic [AW:0]      reads_left;
  logic [AW:0]      pops_left;

  // High in the cycle rd_data carries the word requested one cycle earlier.
  logic             inflight;

  // Two-entry output FIFO.
  logic [WIDTH-1:0] fifo_mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       fifo_cnt;

  logic             pop;
  logic             final_hs;
  logic [2:0]       occ_sum;
  logic [AW:0]      n_sat;
  logic [AW-1:0]    base_mod;
  logic [AW-1:0]    next_addr;

  // Start-time operand conditioning: oversize counts clamp to the buffer
  // depth, and an out-of-range base folds back into 0..HEIGHT_O-1. Because
  // 2^AW < 2*HEIGHT_O a single subtraction is always enough for the fold.
  always_comb begin
    n_sat    = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
    base_mod = ({1'b0, base_addr} >= MAX_WORDS) ? (base_addr - DEPTH_AW) : base_addr;
  end

  // Address increment with explicit wrap, since HEIGHT_O is not necessarily
  // a power of two and natural AW-bit rollover would be wrong.
  always_comb begin
    next_addr = (rd_addr == LAST_ADDR) ? '0 : (rd_addr + 1'b1);
  end

  // Stream side is a straight view of the FIFO head. The head only moves on a
  // pop, so data/valid/last stay put while a word waits for m_ready.
  always_comb begin
    m_valid  = (fifo_cnt != 2'd0);
    m_data   = fifo_mem[rd_ptr];
    m_last   = m_valid && (pops_left == ONE_WORD);
    pop      = m_valid && m_ready;
    final_hs = pop && m_last;
  end

  // Read issue. A read issued now lands in the FIFO at the end of the next
  // cycle, so it is only safe if what the FIFO will hold by then (current
  // occupancy, plus the word already in flight, minus the word leaving now)
  // leaves a free slot. Evaluating this in the issue cycle itself, including
  // this cycle's pop, is what allows one word per cycle with only two
  // entries; it also makes rd_en react to m_ready in the same cycle. The pop
  // term can never underflow because pop implies a non-empty FIFO.
  always_comb begin
    occ_sum = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
    rd_en   = (state == READ) && (occ_sum < 3'd2);
  end

  // Main sequential block: FSM, address/count registers, read pipeline and
  // FIFO bookkeeping. Reset discards in-flight data and empties the FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      rd_addr    <= '0;
      reads_left <= '0;
      pops_left  <= '0;
      inflight   <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_cnt   <= 2'd0;
      busy       <= 1'b0;
      drained    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      drained  <= 1'b0;
      inflight <= rd_en;

      if (rd_en) begin
        rd_addr    <= next_addr;
        reads_left <= reads_left - ONE_WORD;
      end

      // Returned data is pushed unconditionally; the issue rule above
      // guarantees there is room.
      if (inflight) begin
        fifo_mem[wr_ptr] <= rd_data;
        wr_ptr           <= ~wr_ptr;
      end

      if (pop) begin
        rd_ptr    <= ~rd_ptr;
        pops_left <= pops_left - ONE_WORD;
      end

      fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};

      case (state)
        IDLE: begin
          if (start) begin
            if (n_sat == '0) begin
              // Empty drain: acknowledge immediately without touching GBF_o.
              drained <= 1'b1;
            end else begin
              state      <= READ;
              busy       <= 1'b1;
              rd_addr    <= base_mod;
              reads_left <= n_sat;
              pops_left  <= n_sat;
            end
          end
        end
        READ: begin
          if (rd_en && (reads_left == ONE_WORD)) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (final_hs) begin
            state   <= IDLE;
            busy    <= 1'b0;
            drained <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef GBF_O_DRAIN_CLEAR_EN
  // Clear port: the cycle a word is pushed into the FIFO, zero the location
  // it came from. clr_addr is the read address delayed by one cycle, which
  // lines up with the push.
  always_ff @(posedge clk) begin
    if (!rst) begin
      clr_we   <= 1'b0;
      clr_addr <= '0;
    end else begin
      clr_we   <= rd_en;
      clr_addr <= rd_addr;
    end
  end

  assign clr_data = '0;
`endif

endmodule

// File: tb/tb_gbf_o_drain.sv
// ---------------------------------------------------------------------------
// tb_gbf_o_drain
//
// Self-checking bench for gbf_o_drain. A behavioural GBF_o memory answers the
// read port (and the clear port when GBF_O_DRAIN_CLEAR_EN is defined). For
// each drain the expected address list and word list are derived from
// (base + i) mod HEIGHT_O against a snapshot of the memory, and the stream is
// checked word by word, including stall stability, m_last placement, busy and
// drained timing.
// ---------------------------------------------------------------------------
module tb_gbf_o_drain;

  localparam int WIDTH    = 32;
  localparam int HEIGHT_O = 160;
  localparam int AW       = $clog2(HEIGHT_O);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [AW-1:0]    base_addr = '0;
  logic [AW:0]      num_words = '0;
  logic [AW-1:0]    rd_addr;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data = '0;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic             m_last;
  logic             busy;
  logic             drained;
`ifdef GBF_O_DRAIN_CLEAR_EN
  logic [AW-1:0]    clr_addr;
  logic             clr_we;
  logic [WIDTH-1:0] clr_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic             fill_req = 1'b0;
  logic [WIDTH-1:0] gbf  [HEIGHT_O];
  logic [WIDTH-1:0] snap [HEIGHT_O];

  always #5 clk = ~clk;

  gbf_o_drain #(
    .WIDTH    (WIDTH),
    .HEIGHT_O (HEIGHT_O)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .rd_addr   (rd_addr),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .busy      (busy),
    .drained   (drained)
`ifdef GBF_O_DRAIN_CLEAR_EN
    ,
    .clr_addr  (clr_addr),
    .clr_we    (clr_we),
    .clr_data  (clr_data)
`endif
  );

  // Behavioural GBF_o: synchronous read, optional clear write, bulk refill.
  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < HEIGHT_O; i++) begin
        gbf[i] <= $urandom;
      end
    end
`ifdef GBF_O_DRAIN_CLEAR_EN
    else if (clr_we) begin
      gbf[clr_addr] <= '0;
    end
`endif
    if (rd_en) begin
      rd_data <= gbf[rd_addr];
    end
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ready patterns: 0 = always ready, 1 = fixed 1,0,0,1,0,1 cycle, 2 = random.
  function automatic logic ready_for(input int mode, input int c);
    logic r;
    r = 1'b1;
    if (mode == 1) begin
      case (c % 6)
        1, 2, 4: r = 1'b0;
        default: r = 1'b1;
      endcase
    end else if (mode == 2) begin
      r = 1'($urandom_range(0, 1));
    end
    return r;
  endfunction

  // Run one drain. spurious_at: cycle index at which a stray start is driven
  // (-1 for none). reset_at_hs: handshake number at which rst is pulled low
  // (0 for none).
  task automatic apply_stimulus(input int base, input int n, input int mode,
                                input int spurious_at, input int reset_at_hs);
    int               n_eff;
    int               hs;
    int               issued;
    int               c;
    int               first_valid;
    int               outstanding;
    int               addr_q [$];
    logic [WIDTH-1:0] exp_q  [$];
    bit               done;
    bit               last_prev;
    bit               stalled;
    logic [WIDTH-1:0] held_data;
    logic             held_last;

    n_eff = (n > HEIGHT_O) ? HEIGHT_O : n;

    @(negedge clk);
    fill_req = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
    snap = gbf;
    for (int i = 0; i < n_eff; i++) begin
      addr_q.push_back((base + i) % HEIGHT_O);
      exp_q.push_back(snap[(base + i) % HEIGHT_O]);
    end

    start     = 1'b1;
    base_addr = AW'(base);
    num_words = (AW + 1)'(n);
    m_ready   = 1'b1;
    @(negedge clk);
    start = 1'b0;

    if (n_eff == 0) begin
      #1;
      check_output("empty_drained", 64'(drained), 64'(1));
      check_output("empty_busy", 64'(busy), 64'(0));
      check_output("empty_rd_en", 64'(rd_en), 64'(0));
      check_output("empty_valid", 64'(m_valid), 64'(0));
      @(negedge clk);
      #1;
      check_output("empty_drained_once", 64'(drained), 64'(0));
      check_output("empty_busy2", 64'(busy), 64'(0));
      check_output("empty_rd_en2", 64'(rd_en), 64'(0));
      return;
    end

    hs          = 0;
    issued      = 0;
    c           = 0;
    first_valid = -1;
    done        = 1'b0;
    last_prev   = 1'b0;
    stalled     = 1'b0;
    held_data   = '0;
    held_last   = 1'b0;

    while (!done && c < 1000) begin
      m_ready = ready_for(mode, c);
      if (c == spurious_at) begin
        start     = 1'b1;
        base_addr = AW'(7);
        num_words = (AW + 1)'(3);
      end else begin
        start = 1'b0;
      end
      #1;

      check_output("busy", 64'(busy), 64'(hs < n_eff));
      check_output("drained", 64'(drained), 64'(last_prev));

      if (last_prev) begin
        if (mode == 0) begin
          check_output("drained_cycle", 64'(c), 64'(n_eff + 2));
        end
        check_output("idle_valid", 64'(m_valid), 64'(0));
        check_output("idle_rd_en", 64'(rd_en), 64'(0));
        done = 1'b1;
        break;
      end

      outstanding = issued + int'(rd_en) - hs;
      check_output("fifo_bound", 64'(outstanding <= 3), 64'(1));

      if (rd_en) begin
        check_output("read_count", 64'(issued < n_eff), 64'(1));
        if (addr_q.size() > 0) begin
          check_output("rd_addr", 64'(rd_addr), 64'(addr_q.pop_front()));
        end
        if (c == 0) begin
          check_output("first_rd_cycle", 64'(c), 64'(0));
        end
        issued++;
      end

      if (stalled) begin
        check_output("stall_valid", 64'(m_valid), 64'(1));
        check_output("stall_data", 64'(m_data), 64'(held_data));
        check_output("stall_last", 64'(m_last), 64'(held_last));
      end

      if (m_valid) begin
        if (first_valid < 0) begin
          first_valid = c;
          if (mode == 0) begin
            check_output("first_valid_cycle", 64'(c), 64'(2));
          end
        end
        if (m_ready) begin
          if (exp_q.size() > 0) begin
            check_output("m_data", 64'(m_data), 64'(exp_q.pop_front()));
          end else begin
            check_output("extra_word", 64'(hs), 64'(n_eff - 1));
          end
          check_output("m_last", 64'(m_last), 64'(hs == n_eff - 1));
          hs++;
          last_prev = (hs == n_eff);
          stalled   = 1'b0;
        end else begin
          stalled   = 1'b1;
          held_data = m_data;
          held_last = m_last;
        end
      end else begin
        stalled = 1'b0;
      end

      if (reset_at_hs > 0 && m_valid && m_ready && hs == reset_at_hs) begin
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_output("rst_valid", 64'(m_valid), 64'(0));
        check_output("rst_busy", 64'(busy), 64'(0));
        check_output("rst_drained", 64'(drained), 64'(0));
        check_output("rst_rd_en", 64'(rd_en), 64'(0));
        check_output("rst_rd_addr", 64'(rd_addr), 64'(0));
        check_output("rst_last", 64'(m_last), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_output("post_rst_drained", 64'(drained), 64'(0));
        check_output("post_rst_valid", 64'(m_valid), 64'(0));
        check_output("post_rst_rd_en", 64'(rd_en), 64'(0));
        return;
      end

      @(negedge clk);
      c++;
    end

    check_output("timeout", 64'(done), 64'(1));
    check_output("hs_count", 64'(hs), 64'(n_eff));
    check_output("read_total", 64'(issued), 64'(n_eff));
  endtask

  initial begin
    $display("[TB] gbf_o_drain bench starting");
    rst      = 1'b0;
    fill_req = 1'b1;
    repeat (3) @(negedge clk);
    fill_req = 1'b0;
    #1;
    check_output("reset_rd_en", 64'(rd_en), 64'(0));
    check_output("reset_rd_addr", 64'(rd_addr), 64'(0));
    check_output("reset_valid", 64'(m_valid), 64'(0));
    check_output("reset_last", 64'(m_last), 64'(0));
    check_output("reset_data", 64'(m_data), 64'(0));
    check_output("reset_busy", 64'(busy), 64'(0));
    check_output("reset_drained", 64'(drained), 64'(0));
    rst = 1'b1;

    // Basic 10-word drain at full rate.
    apply_stimulus(0, 10, 0, -1, 0);
    // Range that wraps past the top of the buffer.
    apply_stimulus(155, 10, 0, -1, 0);
    // Backpressure with the 1,0,0,1,0,1 pattern.
    apply_stimulus(40, 4, 1, -1, 0);
    apply_stimulus(150, 17, 1, -1, 0);
    // Empty drain.
    apply_stimulus(12, 0, 0, -1, 0);
    // Stray start in the middle of a drain must be ignored.
    apply_stimulus(60, 10, 0, 4, 0);
    // Reset at the third handshake, then a clean drain afterwards.
    apply_stimulus(80, 10, 0, -1, 3);
    apply_stimulus(90, 10, 0, -1, 0);
    // Random ranges and random backpressure.
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(int'($urandom_range(0, HEIGHT_O - 1)), int'($urandom_range(1, 30)), 2, -1, 0);
    end
    // Oversized count clamps to the full buffer.
    apply_stimulus(3, 200, 0, -1, 0);

`ifdef GBF_O_DRAIN_CLEAR_EN
    apply_stimulus(20, 5, 0, -1, 0);
    @(negedge clk);
    #1;
    for (int a = 20; a < 25; a++) begin
      check_output("cleared_word", 64'(gbf[a]), 64'(0));
    end
    check_output("untouched_word", 64'(gbf[25]), 64'(snap[25]));
    check_output("clr_data", 64'(clr_data), 64'(0));
    check_output("clr_we_idle", 64'(clr_we), 64'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
